// File: rtl/debounced_gate_bank.sv
// rtl/debounced_gate_bank.sv - WIDTH-channel synchronise, debounce and invert front-end with change strobes.
module debounced_gate_bank #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] INVERT_MASK   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] changed
);

    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $fatal(1, "debounced_gate_bank: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] s;

    // Synchronisers run regardless of en so a re-enable sees a fresh input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i;
            sync2 <= sync1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_chan
            logic          s_q;
            logic          changed_q;
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q       <= 1'b0;
                    changed_q <= 1'b0;
                    cnt       <= '0;
                end else if (!en || (sync2[k] == s_q)) begin
                    changed_q <= 1'b0;
                    cnt       <= '0;
                end else if (cnt == LAST) begin
                    s_q       <= sync2[k];
                    changed_q <= 1'b1;
                    cnt       <= '0;
                end else begin
                    changed_q <= 1'b0;
                    cnt       <= cnt + 1'b1;
                end
            end

            assign s[k]       = s_q;
            assign changed[k] = changed_q;
        end
    endgenerate

    assign o = s ^ INVERT_MASK;

endmodule

// File: tb/tb_debounced_gate_bank.sv
// tb/tb_debounced_gate_bank.sv - table-driven scoreboard bench for debounced_gate_bank.
module tb_debounced_gate_bank;

    localparam int         WIDTH  = 4;
    localparam int         STABLE = 4;
    localparam logic [3:0] MASK   = 4'b0101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b1;
    logic [WIDTH-1:0] i   = '0;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] changed;

    int checks = 0;
    int errors = 0;

    debounced_gate_bank #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE),
        .INVERT_MASK  (MASK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .i      (i),
        .o      (o),
        .changed(changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] i;
        logic [3:0] o;
        logic [3:0] ch;
        int         n;
    } vec_t;

    typedef struct {
        logic [3:0] o;
        logic [3:0] ch;
        int         tag;
    } exp_t;

    vec_t rows[$];
    exp_t exp_q[$];

    task automatic check_one();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (o !== e.o) begin
                errors++;
                $display("FAIL o_row%0d: got %b expected %b at time %0t", e.tag, o, e.o, $time);
            end
            checks++;
            if (changed !== e.ch) begin
                errors++;
                $display("FAIL changed_row%0d: got %b expected %b at time %0t", e.tag, changed, e.ch, $time);
            end
        end
    endtask

    task automatic run_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            for (int c = 0; c < rows[r].n; c++) begin
                @(negedge clk);
                rst = rows[r].rst;
                en  = rows[r].en;
                i   = rows[r].i;
                exp_q.push_back('{rows[r].o, rows[r].ch, r});
                @(posedge clk);
                #1;
                check_one();
            end
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [3:0] iv,
                       input logic [3:0] ov, input logic [3:0] cv, input int n);
        rows.push_back('{r, e, iv, ov, cv, n});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int split;

        // Reset held with inputs high, then release: all channels accept at edge 6.
        add(1, 1, 4'b1111, 4'b0101, 4'b0000, 3);
        add(0, 1, 4'b1111, 4'b0101, 4'b0000, 5);
        add(0, 1, 4'b1111, 4'b1010, 4'b1111, 1);
        add(0, 1, 4'b1111, 4'b1010, 4'b0000, 2);
        add(1, 1, 4'b0000, 4'b0101, 4'b0000, 1);
        add(0, 1, 4'b0000, 4'b0101, 4'b0000, 2);
        // Channel 0 rises.
        add(0, 1, 4'b0001, 4'b0101, 4'b0000, 5);
        add(0, 1, 4'b0001, 4'b0100, 4'b0001, 1);
        add(0, 1, 4'b0001, 4'b0100, 4'b0000, 2);
        // Channel 1: 3-clock pulse rejected.
        add(0, 1, 4'b0011, 4'b0100, 4'b0000, 3);
        add(0, 1, 4'b0001, 4'b0100, 4'b0000, 6);
        // Channel 1: 4-clock pulse accepted, then falls back.
        add(0, 1, 4'b0011, 4'b0100, 4'b0000, 4);
        add(0, 1, 4'b0001, 4'b0100, 4'b0000, 1);
        add(0, 1, 4'b0001, 4'b0110, 4'b0010, 1);
        add(0, 1, 4'b0001, 4'b0110, 4'b0000, 3);
        add(0, 1, 4'b0001, 4'b0100, 4'b0010, 1);
        add(0, 1, 4'b0001, 4'b0100, 4'b0000, 2);
        // Channel 2 frozen by en=0, accepted 4 edges after re-enable.
        add(0, 0, 4'b0101, 4'b0100, 4'b0000, 10);
        add(0, 1, 4'b0101, 4'b0100, 4'b0000, 3);
        add(0, 1, 4'b0101, 4'b0000, 4'b0100, 1);
        add(0, 1, 4'b0101, 4'b0000, 4'b0000, 2);
        // Channels 0 and 3 flip two clocks apart.
        add(0, 1, 4'b0100, 4'b0000, 4'b0000, 2);
        add(0, 1, 4'b1100, 4'b0000, 4'b0000, 3);
        add(0, 1, 4'b1100, 4'b0001, 4'b0001, 1);
        add(0, 1, 4'b1100, 4'b0001, 4'b0000, 1);
        add(0, 1, 4'b1100, 4'b1001, 4'b1000, 1);
        add(0, 1, 4'b1100, 4'b1001, 4'b0000, 2);
        // Set up o=0011, then start a count on channel 0 (cnt reaches 2).
        add(1, 1, 4'b0110, 4'b0101, 4'b0000, 1);
        add(0, 1, 4'b0110, 4'b0101, 4'b0000, 5);
        add(0, 1, 4'b0110, 4'b0011, 4'b0110, 1);
        add(0, 1, 4'b0110, 4'b0011, 4'b0000, 1);
        add(0, 1, 4'b0111, 4'b0011, 4'b0000, 4);
        split = rows.size() - 1;
        // Recovery after the asynchronous mid-count reset.
        add(1, 1, 4'b0011, 4'b0101, 4'b0000, 2);
        add(0, 1, 4'b0011, 4'b0101, 4'b0000, 5);
        add(0, 1, 4'b0011, 4'b0110, 4'b0011, 1);
        add(0, 1, 4'b0011, 4'b0110, 4'b0000, 2);

        // Reset state before any clock edge.
        #1;
        exp_q.push_back('{MASK, 4'b0000, -1});
        check_one();

        run_rows(0, split);

        // Asynchronous reset mid-cycle must clear o before the next edge.
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back('{MASK, 4'b0000, -2});
        #1;
        check_one();

        run_rows(split + 1, rows.size() - 1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
